// File: rtl/sc_phase_generator.sv
// -----------------------------------------------------------------------------
// sc_phase_generator
//
// Generates the two non-overlapping switch phases (phi1, phi2) for the
// switched-capacitor filter. It also generates an early-falling phi1 (phi1e)
// for bottom-plate sampling. Phase width and dead time are programmable in
// clk cycles. They are latched only at the start of each filter cycle. A
// disable request always lets the current cycle run to its end.
//
// Ports
//   clk          in   system clock; all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   run request; level, sampled on the rising edge
//   half_period  in   phi1/phi2 high time in clks (values < 2 behave as 2)
//   dead_time    in   non-overlap gap in clks (value 0 behaves as 1)
//   phi1         out  phase 1 switch drive
//   phi1e        out  early phase 1; falls one clk before phi1
//   phi2         out  phase 2 switch drive
//   busy         out  high whenever the sequencer is not idle
//   cycle_done   out  one-clk pulse after each completed phi1/phi2 cycle
// -----------------------------------------------------------------------------
module sc_phase_generator #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] half_period,
   input  logic [CNT_W-1:0] dead_time,
   output logic             phi1,
   output logic             phi1e,
   output logic             phi2,
   output logic             busy,
   output logic             cycle_done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PH1  = 3'd1,
      DT12 = 3'd2,
      PH2  = 3'd3,
      DT21 = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hp_q, hp_d;
   logic [CNT_W-1:0] dt_q, dt_d;

   logic phi1_q, phi1_d;
   logic phi1e_q, phi1e_d;
   logic phi2_q, phi2_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   // Clamped configuration. It is only consumed on entry to PH1.
   logic [CNT_W-1:0] hp_clamp;
   logic [CNT_W-1:0] dt_clamp;

   assign hp_clamp = (half_period < TWO) ? TWO : half_period;
   assign dt_clamp = (dead_time == '0) ? ONE : dead_time;

   // Next-state logic. Every state is timed by the single down-counter. A
   // state is left on the cycle its counter reads zero, so a load of N-1
   // gives exactly N cycles in that state.
   always_comb begin
      // NOTE: every signal gets a default before the case, so no path leaves
      // one unassigned and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      hp_d    = hp_q;
      dt_d    = dt_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (en) begin
               state_d = PH1;
               hp_d    = hp_clamp;
               dt_d    = dt_clamp;
               cnt_d   = hp_clamp - ONE;
            end
         end
         PH1: begin
            if (cnt_q == '0) begin
               state_d = DT12;
               cnt_d   = dt_q - ONE;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         DT12: begin
            if (cnt_q == '0) begin
               state_d = PH2;
               cnt_d   = hp_q - ONE;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         PH2: begin
            if (cnt_q == '0) begin
               state_d = DT21;
               cnt_d   = dt_q - ONE;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         DT21: begin
            if (cnt_q == '0) begin
               done_d = 1'b1;
               if (en) begin
                  // Relatch: config changes take effect only here.
                  state_d = PH1;
                  hp_d    = hp_clamp;
                  dt_d    = dt_clamp;
                  cnt_d   = hp_clamp - ONE;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are decoded from the next state and registered. The ports
      // then change on the same edge as the state, with no decode glitches.
      phi1_d  = (state_d == PH1);
      phi1e_d = (state_d == PH1) && (cnt_d != '0);
      phi2_d  = (state_d == PH2);
      busy_d  = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: all state, including the latched config, is reset. A mid-cycle
         // reset therefore kills the phases at once and restarts from known
         // defaults.
         state_q <= IDLE;
         cnt_q   <= '0;
         hp_q    <= TWO;
         dt_q    <= ONE;
         phi1_q  <= 1'b0;
         phi1e_q <= 1'b0;
         phi2_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hp_q    <= hp_d;
         dt_q    <= dt_d;
         phi1_q  <= phi1_d;
         phi1e_q <= phi1e_d;
         phi2_q  <= phi2_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign phi1       = phi1_q;
   assign phi1e      = phi1e_q;
   assign phi2       = phi2_q;
   assign busy       = busy_q;
   assign cycle_done = done_q;

endmodule

// File: tb/tb_sc_phase_generator.sv
// -----------------------------------------------------------------------------
// tb_sc_phase_generator
//
// Directed bench for sc_phase_generator. A table of segments
// {en, half_period, dead_time, cycles, expected outputs} covers nominal,
// clamped and config-change runs. Each segment checks the outputs after every
// rising edge. Hand-written sequences cover the reset state, graceful stop
// and a mid-PH2 asynchronous reset.
// Expected output vector bit order: {phi1, phi1e, phi2, busy, cycle_done}.
// -----------------------------------------------------------------------------
module tb_sc_phase_generator;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] half_period;
   logic [7:0] dead_time;
   logic       phi1;
   logic       phi1e;
   logic       phi2;
   logic       busy;
   logic       cycle_done;

   int n_total;
   int n_pass;

   typedef struct {
      logic       en;
      logic [7:0] hp;
      logic [7:0] dt;
      int         n;
      logic [4:0] exp;
   } vec_t;

   vec_t vecs[$];

   sc_phase_generator #(.CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .half_period(half_period),
      .dead_time  (dead_time),
      .phi1       (phi1),
      .phi1e      (phi1e),
      .phi2       (phi2),
      .busy       (busy),
      .cycle_done (cycle_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic add(input logic e, input logic [7:0] hp, input logic [7:0] dt,
                      input int n, input logic [4:0] exp);
      vec_t v;
      v.en = e; v.hp = hp; v.dt = dt; v.n = n; v.exp = exp;
      vecs.push_back(v);
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] outs();
      return {phi1, phi1e, phi2, busy, cycle_done};
   endfunction

   initial begin
      int cnt;
      int phi2_cnt;

      n_total = 0;
      n_pass  = 0;

      // Reset held with en=1: all outputs stay low.
      rst_n = 1'b0; en = 1'b1; half_period = 8'd4; dead_time = 8'd2;
      repeat (3) tick();
      check("reset_phi1",  32'(phi1), 32'd0);
      check("reset_phi1e", 32'(phi1e), 32'd0);
      check("reset_phi2",  32'(phi2), 32'd0);
      check("reset_busy",  32'(busy), 32'd0);
      check("reset_done",  32'(cycle_done), 32'd0);
      rst_n = 1'b1;

      // Nominal hp=4 dt=2: three cycles, en dropped during the third.
      // Cycle 1 (no cycle_done on first PH1 entry).
      add(1, 4, 2, 1, 5'b11010);
      add(1, 4, 2, 2, 5'b11010);
      add(1, 4, 2, 1, 5'b10010);
      add(1, 4, 2, 2, 5'b00010);
      add(1, 4, 2, 4, 5'b00110);
      add(1, 4, 2, 2, 5'b00010);
      // Cycle 2: cycle_done coincides with phi1 rising; period 12.
      add(1, 4, 2, 1, 5'b11011);
      add(1, 4, 2, 2, 5'b11010);
      add(1, 4, 2, 1, 5'b10010);
      add(1, 4, 2, 2, 5'b00010);
      add(1, 4, 2, 4, 5'b00110);
      add(1, 4, 2, 2, 5'b00010);
      // Cycle 3: en low from its 2nd clk, the cycle still completes.
      add(1, 4, 2, 1, 5'b11011);
      add(0, 4, 2, 2, 5'b11010);
      add(0, 4, 2, 1, 5'b10010);
      add(0, 4, 2, 2, 5'b00010);
      add(0, 4, 2, 4, 5'b00110);
      add(0, 4, 2, 2, 5'b00010);
      add(0, 4, 2, 1, 5'b00001);   // stop: busy falls with cycle_done
      add(0, 4, 2, 2, 5'b00000);

      // Clamping: hp=0 -> 2, dt=0 -> 1, period 6.
      add(1, 0, 0, 1, 5'b11010);
      add(1, 0, 0, 1, 5'b10010);
      add(1, 0, 0, 1, 5'b00010);
      add(1, 0, 0, 2, 5'b00110);
      add(1, 0, 0, 1, 5'b00010);
      add(1, 0, 0, 1, 5'b11011);
      add(1, 0, 0, 1, 5'b10010);
      add(1, 0, 0, 1, 5'b00010);
      add(1, 0, 0, 2, 5'b00110);
      add(1, 0, 0, 1, 5'b00010);
      add(0, 0, 0, 1, 5'b00001);
      add(0, 0, 0, 1, 5'b00000);

      // Config change: hp 4 -> 6 in mid-PH2. Current PH2 keeps 4 clks; next
      // cycle is 6+2+6+2 = 16.
      add(1, 4, 2, 1, 5'b11010);
      add(1, 4, 2, 2, 5'b11010);
      add(1, 4, 2, 1, 5'b10010);
      add(1, 4, 2, 2, 5'b00010);
      add(1, 4, 2, 2, 5'b00110);
      add(1, 6, 2, 2, 5'b00110);
      add(1, 6, 2, 2, 5'b00010);
      add(1, 6, 2, 1, 5'b11011);
      add(1, 6, 2, 4, 5'b11010);
      add(1, 6, 2, 1, 5'b10010);
      add(1, 6, 2, 2, 5'b00010);
      add(1, 6, 2, 6, 5'b00110);
      add(1, 6, 2, 2, 5'b00010);
      add(0, 6, 2, 1, 5'b00001);
      add(0, 6, 2, 1, 5'b00000);

      foreach (vecs[i]) begin
         en = vecs[i].en; half_period = vecs[i].hp; dead_time = vecs[i].dt;
         for (int c = 0; c < vecs[i].n; c++) begin
            tick();
            check($sformatf("vec%0d_c%0d", i, c), 32'(outs()), 32'(vecs[i].exp));
            check($sformatf("vec%0d_c%0d_overlap", i, c), 32'(phi1 & phi2), 32'd0);
         end
      end

      // Graceful stop: en dropped in the 2nd clk of PH1. busy falls with
      // cycle_done rising 11 clks after that edge.
      en = 1'b1; half_period = 8'd4; dead_time = 8'd2;
      tick();
      check("stop_start", 32'(outs()), 32'(5'b11010));
      tick();
      en = 1'b0;
      cnt = 0;
      phi2_cnt = 0;
      while (busy && cnt < 40) begin
         tick();
         cnt++;
         if (phi2) phi2_cnt++;
      end
      check("stop_latency", 32'(cnt), 32'd11);
      check("stop_done", 32'(cycle_done), 32'd1);
      check("stop_ph2_len", 32'(phi2_cnt), 32'd4);
      tick();
      check("stop_idle", 32'(outs()), 32'd0);

      // Async reset in mid-PH2: outputs drop without a clock edge.
      en = 1'b1;
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!phi2 && cnt < 40);
      check("arst_reach_ph2", 32'(phi2), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("arst_phi2", 32'(phi2), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_outs", 32'(outs()), 32'd0);
      #1 rst_n = 1'b1;
      tick();
      check("arst_restart", 32'(outs()), 32'(5'b11010));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
